// File: rtl/bcd_a_binario_pkg.sv
// Shared definitions for the BCD-to-binary decoder: FSM encodings and digit constants.
// Optional feature macro: BCD_DIGIT_CHECK_EN (see bcd_a_binario.sv).
package bcd_a_binario_pkg;

    localparam int DIG_W = 4;
    localparam logic [DIG_W-1:0] BCD_MAX_DIGIT = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_mac10.sv
// Combinational multiply-by-ten-and-add step: out = acc*10 + digit.
// acc*10 is built from two shifts so no multiplier is inferred.
module bcd_mac10
    import bcd_a_binario_pkg::*;
#(
    parameter int WBIN = 20
) (
    input  logic [WBIN-1:0]  acc,
    input  logic [DIG_W-1:0] digit,
    output logic [WBIN-1:0]  out
);

    // Keeping only the low WBIN bits of the sum is identical to computing it
    // WBIN+4 wide and truncating, since addition is exact modulo 2^WBIN.
    assign out = (acc << 3) + (acc << 1) + {{(WBIN-DIG_W){1'b0}}, digit};

endmodule

// File: rtl/bcd_a_binario.sv
// Sequential BCD-to-binary decoder, MSD first, one digit per clock, start/busy/done handshake.
// Define BCD_DIGIT_CHECK_EN to flag digits > 9 (err=1, bin forced to 0).
module bcd_a_binario
    import bcd_a_binario_pkg::*;
#(
    parameter int NDIG = 6,
    parameter int WBIN = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIG_W*NDIG-1:0] dbcd,
    output logic                  busy,
    output logic                  done,
    output logic [WBIN-1:0]       bin,
    output logic                  err
);

    localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NDIG - 1);

    state_t                  state_q;
    logic [DIG_W*NDIG-1:0]   sreg_q;
    logic [WBIN-1:0]         acc_q;
    logic [WBIN-1:0]         acc_d;
    logic [CW-1:0]           cnt_q;
    logic                    busy_q;
    logic                    done_q;
    logic [WBIN-1:0]         bin_q;
    logic [DIG_W-1:0]        dig;

    assign dig = sreg_q[DIG_W*NDIG-1 -: DIG_W];

    bcd_mac10 #(.WBIN(WBIN)) u_mac (
        .acc   (acc_q),
        .digit (dig),
        .out   (acc_d)
    );

`ifdef BCD_DIGIT_CHECK_EN
    logic err_acc_q;
    logic err_q;
    logic dig_bad;
    assign dig_bad = (dig > BCD_MAX_DIGIT);
    assign err     = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sreg_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bin_q   <= '0;
`ifdef BCD_DIGIT_CHECK_EN
            err_acc_q <= 1'b0;
            err_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        sreg_q  <= dbcd;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
`ifdef BCD_DIGIT_CHECK_EN
                        err_acc_q <= 1'b0;
`endif
                        state_q <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    acc_q  <= acc_d;
                    sreg_q <= {sreg_q[DIG_W*NDIG-DIG_W-1:0], {DIG_W{1'b0}}};
                    cnt_q  <= cnt_q + CW'(1);
`ifdef BCD_DIGIT_CHECK_EN
                    err_acc_q <= err_acc_q | dig_bad;
`endif
                    if (cnt_q == CNT_LAST) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q <= 1'b1;
`ifdef BCD_DIGIT_CHECK_EN
                    bin_q <= err_acc_q ? '0 : acc_q;
                    err_q <= err_acc_q;
`else
                    bin_q <= acc_q;
`endif
                    // Back-to-back: a start seen here skips IDLE entirely.
                    if (start) begin
                        sreg_q  <= dbcd;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
`ifdef BCD_DIGIT_CHECK_EN
                        err_acc_q <= 1'b0;
`endif
                        state_q <= ST_CONV;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bin  = bin_q;

endmodule

// File: tb/tb_bcd_a_binario.sv
// Directed-vector bench for bcd_a_binario: latency, values, back-to-back, ignored start, async reset.
module tb_bcd_a_binario;

    logic        clk;
    logic        rst;
    logic        start;
    logic [23:0] dbcd;
    logic        busy;
    logic        done;
    logic [19:0] bin;
    logic        err;

    int nvec = 0;
    int nerr = 0;

    bcd_a_binario #(.NDIG(6), .WBIN(20)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .dbcd  (dbcd),
        .busy  (busy),
        .done  (done),
        .bin   (bin),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Counts rising edges until done is seen; 0 means the bound expired.
    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic count_dones(input int ncyc, output int n);
        n = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk); #1;
            if (done) n++;
        end
    endtask

    task automatic conv(input string tag, input logic [23:0] d,
                        input logic [19:0] exp_bin, input logic exp_err);
        int cyc;
        @(negedge clk);
        dbcd  = d;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dbcd  = 24'h555555;
        chk({tag, ".busy"}, 32'(busy), 32'd1);
        wait_done(cyc);
        chk({tag, ".lat"}, 32'(cyc), 32'd7);
        chk({tag, ".bin"}, 32'(bin), 32'(exp_bin));
        chk({tag, ".err"}, 32'(err), 32'(exp_err));
        @(posedge clk); #1;
        chk({tag, ".pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int cyc;
        int n;
        rst   = 1'b1;
        start = 1'b0;
        dbcd  = 24'h0;
        repeat (2) @(negedge clk);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.bin",  32'(bin),  32'd0);
        chk("rst.err",  32'(err),  32'd0);
        rst = 1'b0;

        conv("v123456", 24'h123456, 20'h1E240, 1'b0);
        chk("idle.busy", 32'(busy), 32'd0);
        conv("v999999", 24'h999999, 20'hF423F, 1'b0);
        conv("v000000", 24'h000000, 20'h00000, 1'b0);
`ifdef BCD_DIGIT_CHECK_EN
        conv("v00000A", 24'h00000A, 20'd0, 1'b1);
        conv("v000901", 24'h000901, 20'd901, 1'b0);
`else
        conv("v00000A", 24'h00000A, 20'd10, 1'b0);
        conv("v0000A0", 24'h0000A0, 20'd100, 1'b0);
`endif

        // start pulsed in the middle of a conversion must be ignored
        @(negedge clk);
        dbcd  = 24'h000321;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        dbcd  = 24'h000777;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc);
        chk("ign.lat", 32'(cyc), 32'd4);
        chk("ign.bin", 32'(bin), 32'd321);
        count_dones(12, n);
        chk("ign.ndone", 32'(n), 32'd0);

        // start held high: second operand captured on the DONE cycle
        @(negedge clk);
        dbcd  = 24'h000042;
        start = 1'b1;
        @(posedge clk); #1;
        dbcd = 24'h000100;
        wait_done(cyc);
        start = 1'b0;
        chk("b2b.lat1", 32'(cyc), 32'd7);
        chk("b2b.bin1", 32'(bin), 32'd42);
        chk("b2b.busy", 32'(busy), 32'd1);
        wait_done(cyc);
        chk("b2b.lat2", 32'(cyc), 32'd7);
        chk("b2b.bin2", 32'(bin), 32'd100);

        // async reset mid-conversion
        @(negedge clk);
        dbcd  = 24'h654321;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mrst.busy", 32'(busy), 32'd0);
        chk("mrst.done", 32'(done), 32'd0);
        chk("mrst.bin",  32'(bin),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        count_dones(10, n);
        chk("mrst.ndone", 32'(n), 32'd0);
        conv("after_rst", 24'h123456, 20'h1E240, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
